data_mem_responder: RTL and testbench

Synchronous data-memory responder for the single-cycle RISC-V core's load/store path. Accepts one load or store request per cycle over a valid/ready handshake, performs RV32I sized accesses (byte, halfword, word) against an internal word-organised array with byte-lane writes, and returns a registered response with sign/zero-extended load data or an error flag. It is the memory end of the request interface that the core's load/store logic drives, replacing direct block-RAM port wiring.

---
 rtl/data_mem_responder_if.sv | 29 ++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the core's LSU and the data memory.
// Latency: none, wires only.
// Backpressure: req_ready gates requests; rsp_ready gates responses.
interface data_mem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Memory side: accepts requests, produces responses.
    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory: sized loads/stores against a word array with byte-lane writes.
// Latency: response registered, visible one cycle after the accept edge.
// Backpressure: one response slot; req_ready drops while a response waits on rsp_ready.
module data_mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state, state_nxt;

    // Contents survive rst; zero at power-up.
    logic [31:0] mem [0:DEPTH-1] = '{default: 32'h0};

    logic              accept;
    logic              slot_free;
    logic              rsp_valid_q;
    logic              req_ready_c;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        off;
    logic [31:0]       rd_word;
    logic [15:0]       rd_low;
    logic              is_err;
    logic              wr_en;
    logic [3:0]        lane_en;
    logic [31:0]       wr_data;
    logic [31:0]       ld_data;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    assign word_idx  = bus.req_addr[ADDR_W+1:2];
    assign off       = bus.req_addr[1:0];
    assign rd_word   = mem[word_idx];
    assign rd_low    = 16'(rd_word >> {off, 3'b000});
    // A request in the reset cycle is never taken, so it cannot write the array.
    assign slot_free = (state == EMPTY) || bus.rsp_ready;
    assign accept    = bus.req_valid && slot_free && !rst;
    assign wr_en     = accept && bus.req_we && !is_err;

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // Response slot state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Slot next-state and handshake outputs.
    always_comb begin
        state_nxt   = state;
        rsp_valid_q = 1'b0;
        req_ready_c = 1'b1;
        case (state)
            EMPTY: begin
                if (accept) state_nxt = FULL;
            end
            FULL: begin
                rsp_valid_q = 1'b1;
                req_ready_c = bus.rsp_ready;
                if (bus.rsp_ready && !accept) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Decode size/alignment, build store lanes and extended load data.
    always_comb begin
        is_err  = 1'b0;
        lane_en = 4'b0000;
        wr_data = bus.req_wdata;
        ld_data = 32'h0;
        if (bus.req_we) begin
            case (bus.req_funct3)
                3'b000: begin
                    lane_en = 4'b0001 << off;
                    wr_data = {4{bus.req_wdata[7:0]}};
                end
                3'b001: begin
                    is_err  = off[0];
                    lane_en = 4'b0011 << off;
                    wr_data = {2{bus.req_wdata[15:0]}};
                end
                3'b010: begin
                    is_err  = |off;
                    lane_en = 4'b1111;
                end
                default: is_err = 1'b1;
            endcase
        end else begin
            case (bus.req_funct3)
                3'b000: ld_data = {{24{rd_low[7]}}, rd_low[7:0]};
                3'b001: begin
                    is_err  = off[0];
                    ld_data = {{16{rd_low[15]}}, rd_low};
                end
                3'b010: begin
                    is_err  = |off;
                    ld_data = rd_word;
                end
                3'b100: ld_data = {24'h0, rd_low[7:0]};
                3'b101: begin
                    is_err  = off[0];
                    ld_data = {16'h0, rd_low};
                end
                default: is_err = 1'b1;
            endcase
        end
    end

    // Byte-lane array write at the accept edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && lane_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    // Response data/error capture; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (accept) begin
            rsp_rdata_q <= (bus.req_we || is_err) ? 32'h0 : ld_data;
            rsp_err_q   <= is_err;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-addressed reference memory.
// Latency: expects each accepted request's response one cycle after its accept edge.
// Backpressure: drives rsp_ready low in directed and random phases and checks hold behaviour.
module tb_data_mem_responder;
    localparam int ADDR_W = 8;
    localparam int NBYTES = 4 << ADDR_W;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [0:NBYTES-1];
    logic        pend_v;
    logic [31:0] pend_d;
    logic        pend_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed memory, size = 2^funct3[1:0] bytes, little-endian.
    task automatic predict(input logic we, input logic [ADDR_W+1:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int          n;
        int          a;
        logic        legal;
        logic [31:0] val;
        n     = 1 << f3[1:0];
        a     = int'(addr);
        legal = we ? (f3 <= 3'd2) : (f3 inside {F_B, F_H, F_W, F_BU, F_HU});
        e     = !legal || ((a % n) != 0);
        rd    = 32'h0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                val = 32'h0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[a + i]) << (8*i));
                if (!f3[2] && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                rd = val;
            end
        end
    endtask

    // One clock of stimulus with handshake prediction and response checking.
    task automatic step(input logic r, input logic v, input logic we, input logic [ADDR_W+1:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd, input logic rdy);
        logic        acc;
        logic [31:0] rd;
        logic        e;
        rst            = r;
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        bus.req_wdata  = wd;
        bus.rsp_ready  = rdy;
        #1;
        if (!r) check("req_ready", 32'(bus.req_ready), 32'(!pend_v || rdy));
        acc = !r && v && (!pend_v || rdy);
        @(posedge clk);
        #1;
        if (r) begin
            pend_v = 1'b0;
            pend_d = 32'h0;
            pend_e = 1'b0;
        end else if (acc) begin
            predict(we, addr, f3, wd, rd, e);
            pend_v = 1'b1;
            pend_d = rd;
            pend_e = e;
        end else if (rdy) begin
            pend_v = 1'b0;
        end
        check("rsp_valid", 32'(bus.rsp_valid), 32'(pend_v));
        if (pend_v || r) begin
            check("rsp_rdata", bus.rsp_rdata, pend_d);
            check("rsp_err", 32'(bus.rsp_err), 32'(pend_e));
        end
    endtask

    task automatic req(input logic we, input logic [ADDR_W+1:0] addr, input logic [2:0] f3,
                       input logic [31:0] wd);
        step(1'b0, 1'b1, we, addr, f3, wd, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, F_W, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] rnd;
        for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
        pend_v = 1'b0;
        pend_d = 32'h0;
        pend_e = 1'b0;

        // Reset with a store presented: no write, outputs cleared.
        step(1'b1, 1'b1, 1'b1, 10'h000, F_W, 32'hDEAD_BEEF, 1'b1);
        step(1'b1, 1'b1, 1'b1, 10'h000, F_W, 32'hDEAD_BEEF, 1'b1);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        idle();
        req(1'b0, 10'h000, F_W, 32'h0);
        check("rst_no_write", bus.rsp_rdata, 32'h0);

        // Word round trip.
        req(1'b1, 10'h004, F_W, 32'h1234_5678);
        check("sw_rdata_zero", bus.rsp_rdata, 32'h0);
        req(1'b0, 10'h004, F_W, 32'h0);
        check("lw4", bus.rsp_rdata, 32'h1234_5678);
        req(1'b0, 10'h007, F_BU, 32'h0);
        check("lbu7", bus.rsp_rdata, 32'h0000_0012);
        req(1'b0, 10'h006, F_H, 32'h0);
        check("lh6", bus.rsp_rdata, 32'h0000_1234);

        // Sub-word stores and extension.
        req(1'b1, 10'h009, F_B, 32'h0000_00F0);
        req(1'b1, 10'h00A, F_H, 32'h0000_8001);
        req(1'b0, 10'h008, F_W, 32'h0);
        check("lw8", bus.rsp_rdata, 32'h8001_F000);
        req(1'b0, 10'h009, F_B, 32'h0);
        check("lb9", bus.rsp_rdata, 32'hFFFF_FFF0);
        req(1'b0, 10'h00A, F_HU, 32'h0);
        check("lhuA", bus.rsp_rdata, 32'h0000_8001);
        req(1'b0, 10'h00A, F_H, 32'h0);
        check("lhA", bus.rsp_rdata, 32'hFFFF_8001);

        // Error cases.
        req(1'b0, 10'h002, F_W, 32'h0);
        check("err_lw_mis", 32'(bus.rsp_err), 32'd1);
        req(1'b1, 10'h005, F_H, 32'h0000_FFFF);
        check("err_sh_mis", 32'(bus.rsp_err), 32'd1);
        req(1'b0, 10'h000, 3'b011, 32'h0);
        check("err_ld_f3", 32'(bus.rsp_err), 32'd1);
        req(1'b1, 10'h004, 3'b100, 32'hFFFF_FFFF);
        check("err_st_f3", 32'(bus.rsp_err), 32'd1);
        req(1'b0, 10'h004, F_W, 32'h0);
        check("lw4_after_err", bus.rsp_rdata, 32'h1234_5678);

        // Backpressure: pending store held off while the load response stalls.
        req(1'b0, 10'h004, F_W, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 10'h004, F_W, 32'hAAAA_AAAA, 1'b0);
            check("bp_hold", bus.rsp_rdata, 32'h1234_5678);
        end
        step(1'b0, 1'b1, 1'b1, 10'h004, F_W, 32'hAAAA_AAAA, 1'b1);
        req(1'b0, 10'h004, F_W, 32'h0);
        check("lw4_after_bp", bus.rsp_rdata, 32'hAAAA_AAAA);

        // Throughput, then reset mid-stream.
        for (int i = 0; i < 8; i++) req(1'b1, 10'(4*i), F_W, $urandom);
        for (int i = 0; i < 4; i++) req(1'b0, 10'(4*i), F_W, 32'h0);
        step(1'b1, 1'b1, 1'b0, 10'h010, F_W, 32'h0, 1'b1);
        rnd = $urandom;
        step(1'b1, 1'b1, 1'b1, 10'h010, F_W, rnd, 1'b1);
        for (int i = 0; i < 3; i++) idle();
        req(1'b0, 10'h010, F_W, 32'h0);

        // Random traffic over low addresses and the top word, with stalls and gaps.
        for (int i = 0; i < 400; i++) begin
            logic [ADDR_W+1:0] a;
            a = ($urandom_range(0, 7) == 0) ? 10'(10'h3FC + $urandom_range(0, 3))
                                            : 10'($urandom_range(0, 63));
            step(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
